ht_task_queue: RTL
==================

Name: ht_task_queue

Overview:
- Slave-side endpoint for hash-table task transactions (key, value, cmd, valid/ready).
- Accepts tasks from a task master, such as a host or command decoder, and buffers them in an order-preserving FIFO.
- Re-issues the buffered tasks as a task master to the hash-table engine.
- Decouples the upstream producer from engine backpressure and keeps per-command accept statistics.

Parameters:
KEY_WIDTH, 32, width of task key
VALUE_WIDTH, 16, width of task value
DEPTH, 8, FIFO entries; power of 2, >= 2
CNT_WIDTH, 32, width of each statistics counter

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  asynchronous, active-low reset
task_in  ht_task_if.slave  KEY_WIDTH+VALUE_WIDTH+cmd  incoming tasks; this block drives ready
task_out  ht_task_if.master  KEY_WIDTH+VALUE_WIDTH+cmd  outgoing tasks to engine; this block drives key/value/cmd/valid
stat_clear_i  input  1  synchronous clear of all statistics counters
usedw_o  output  $clog2(DEPTH)+1  current number of stored entries
cnt_search_o  output  CNT_WIDTH  accepted SEARCH tasks
cnt_insert_o  output  CNT_WIDTH  accepted INSERT tasks
cnt_delete_o  output  CNT_WIDTH  accepted DELETE tasks

Behaviour:
- Reset (rst_i low, asynchronous assert, synchronous release):
  - FIFO is emptied.
  - task_out.valid = 0; task_out.key/value/cmd = 0.
  - task_in.ready = 0 while reset is asserted.
  - usedw_o = 0; all counters = 0.
- After reset release:
  - task_in.ready = 1 from the first clock on.
  - Reset mid-operation drops all buffered tasks; no partial task is ever presented.
- Accept: occurs on an edge where task_in.valid && task_in.ready. Key, value and cmd are captured on that edge.
- task_in.ready = (usedw_o != DEPTH). It depends only on registered state, so there is no combinational path from task_out.ready.
- Pop: occurs on an edge where task_out.valid && task_out.ready.
- task_out.valid = (usedw_o != 0). The output is first-word-fall-through and registered: key/value/cmd show the head entry.
- Latency: a task accepted on edge N into an empty queue gives task_out.valid = 1 after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Stall: while task_out.valid && !task_out.ready, task_out key/value/cmd/valid hold stable.
- Ordering: strict FIFO; output order equals accept order.
- Simultaneous accept and pop:
  - usedw_o is unchanged.
  - Pointers advance independently.
  - Legal at any non-full, non-empty level.
- Full (usedw_o == DEPTH): ready = 0. A pop in that cycle frees the entry, but ready rises only in the next cycle.
- Empty: valid = 0. A pop request has no effect because valid is 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. usedw_o is held in a separate counter ranging 0..DEPTH.
- Statistics:
  - On each accept, the counter matching task_in.cmd increments by 1.
  - Counters wrap modulo 2^CNT_WIDTH.
  - Commands other than SEARCH/INSERT/DELETE are queued but not counted.
  - When stat_clear_i is high, all counters become 0 next cycle, and any accept in that same cycle is not counted. Clearing does not affect the FIFO.
- task_in key/value/cmd are ignored when task_in.valid = 0.

Decomposition:
- ht_cmd_t (SEARCH/INSERT/DELETE encodings) comes from the existing hash_table package.
- Add HT_TASK_QUEUE_DEPTH (default 8) to that package.
- One sub-module, ht_task_fifo: storage array, read/write pointers, usedw counter and the FWFT output register, with a generic data width of KEY_WIDTH+VALUE_WIDTH+$bits(ht_cmd_t).
- ht_task_queue instantiates ht_task_fifo, packs/unpacks the task fields, and adds the statistics counters.

Test Plan:
- Reset then idle:
  - In the cycle after release, ready=1, valid=0, usedw_o=0, all counters 0.
  - With rst_i held low mid-stream after 3 accepts: valid drops immediately and usedw_o=0.
- Single task INSERT key=0x12345678 value=0xBEEF accepted on edge N, task_out.ready=1:
  - task_out.valid=1 in cycle N+1 with the same fields.
  - Popped at edge N+1; usedw_o returns to 0.
  - cnt_insert_o=1.
- Fill with task_out.ready=0: push 8 tasks with keys 0..7.
  - ready=0 once usedw_o=8; a 9th valid is not accepted.
  - Release task_out.ready: output keys 0..7 in order, and ready rises the cycle after the first pop.
- Simultaneous push and pop at usedw_o=4 for 20 cycles:
  - usedw_o stays 4.
  - Output sequence equals input sequence delayed by 4 entries, exercising pointer wrap.
- Stall hold: task_out.ready toggled randomly 0/1 for 100 cycles.
  - task_out fields never change while valid && !ready.
  - No loss or duplication: scoreboard matches all 100 keys.
- Statistics:
  - 5 SEARCH, 3 INSERT, 2 DELETE accepted gives counters 5/3/2.
  - stat_clear_i asserted on the same edge as a SEARCH accept gives all counters 0 and cnt_search_o=0 the next cycle.
  - The FIFO still delivers that SEARCH.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared hash-table definitions: command encodings and task-queue sizing.
package hash_table_pkg;

    // Task command encodings; HT_NOP is queued like any other task but never counted
    typedef enum logic [1:0] {
        HT_SEARCH = 2'd0,
        HT_INSERT = 2'd1,
        HT_DELETE = 2'd2,
        HT_NOP    = 2'd3
    } ht_cmd_t;

    localparam int HT_CMD_W            = $bits(ht_cmd_t);
    localparam int HT_TASK_QUEUE_DEPTH = 8;

endpackage

// File: rtl/ht_task_if.sv
// Hash-table task channel: key/value/cmd qualified by a valid/ready handshake.
interface ht_task_if #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 16
) ();

    logic [KEY_WIDTH-1:0]     key;
    logic [VALUE_WIDTH-1:0]   value;
    hash_table_pkg::ht_cmd_t  cmd;
    logic                     valid;
    logic                     ready;

    modport master (output key, value, cmd, valid, input ready);
    modport slave  (input key, value, cmd, valid, output ready);

endinterface

// File: rtl/ht_task_fifo.sv
// Order-preserving FIFO with a registered first-word-fall-through head.
// Occupancy is kept in its own counter so full/empty never need a pointer MSB.
module ht_task_fifo #(
    parameter int DATA_W = 50,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  usedw
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_nxt;
    logic              in_en;
    logic              push;
    logic              pop;

    // Ready is held low through reset and rises on the first clock after release.
    assign wr_ready = in_en && (usedw != CNT_W'(DEPTH));
    assign rd_valid = (usedw != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign rd_nxt   = rd_ptr + PTR_W'(1);

    // Storage array; contents need no reset because usedw gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and the post-reset input enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
            in_en  <= 1'b0;
        end else begin
            in_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   usedw <= usedw + CNT_W'(1);
                2'b01:   usedw <= usedw - CNT_W'(1);
                default: usedw <= usedw;
            endcase
        end
    end

    // Head register: loads the next-oldest entry on pop, or the incoming word when
    // it becomes the head (empty queue, or popping the last entry while pushing).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (pop) begin
            if (usedw != CNT_W'(1)) rd_data <= mem[rd_nxt];
            else if (push)          rd_data <= wr_data;
        end else if (push && (usedw == '0)) begin
            rd_data <= wr_data;
        end
    end

endmodule

// File: rtl/ht_task_queue.sv
// Hash-table task queue: buffers tasks from a producer, re-issues them in order
// to the engine, and counts accepted SEARCH/INSERT/DELETE tasks.
module ht_task_queue
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 16,
    parameter int DEPTH       = HT_TASK_QUEUE_DEPTH,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ht_task_if.slave               task_in,
    ht_task_if.master              task_out,
    input  logic                   stat_clear_i,
    output logic [$clog2(DEPTH):0] usedw_o,
    output logic [CNT_WIDTH-1:0]   cnt_search_o,
    output logic [CNT_WIDTH-1:0]   cnt_insert_o,
    output logic [CNT_WIDTH-1:0]   cnt_delete_o
);

    localparam int DATA_W = KEY_WIDTH + VALUE_WIDTH + HT_CMD_W;

    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              wr_ready;
    logic              rd_valid;
    logic              accept;

    // Task word layout: {key, value, cmd}
    assign wr_data = {task_in.key, task_in.value, task_in.cmd};
    assign accept  = task_in.valid && wr_ready;

    ht_task_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .wr_valid (task_in.valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (task_out.ready),
        .rd_data  (rd_data),
        .usedw    (usedw_o)
    );

    assign task_in.ready  = wr_ready;
    assign task_out.valid = rd_valid;
    assign task_out.key   = rd_data[DATA_W-1 -: KEY_WIDTH];
    assign task_out.value = rd_data[HT_CMD_W +: VALUE_WIDTH];
    assign task_out.cmd   = ht_cmd_t'(rd_data[HT_CMD_W-1:0]);

    // Per-command accept counters; clear wins over a same-cycle accept
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_search_o <= '0;
            cnt_insert_o <= '0;
            cnt_delete_o <= '0;
        end else if (stat_clear_i) begin
            cnt_search_o <= '0;
            cnt_insert_o <= '0;
            cnt_delete_o <= '0;
        end else if (accept) begin
            case (task_in.cmd)
                HT_SEARCH: cnt_search_o <= cnt_search_o + CNT_WIDTH'(1);
                HT_INSERT: cnt_insert_o <= cnt_insert_o + CNT_WIDTH'(1);
                HT_DELETE: cnt_delete_o <= cnt_delete_o + CNT_WIDTH'(1);
                default:   ;
            endcase
        end
    end

endmodule
